// File: rtl/vwb_rr_scheduler.sv
// vwb_rr_scheduler: round-robin sharing of one vector-weight-bias MAC engine
// between NumReq requester streams, with a credit-guarded output FIFO.
module vwb_rr_scheduler #(
    parameter int unsigned NumReq       = 4,
    parameter int unsigned InVecLength  = 16,
    parameter int unsigned WorkingRegs  = 4,
    parameter int unsigned NBits        = 16,
    parameter int unsigned MacLatency   = 1,
    parameter int unsigned OutFifoDepth = 8,
    localparam int unsigned Chunks = InVecLength / WorkingRegs,
    localparam int unsigned AW     = (Chunks > 1) ? $clog2(Chunks) : 1,
    localparam int unsigned TW     = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned DW     = WorkingRegs * NBits
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NumReq-1:0]    req_valid,
    input  logic [NumReq*DW-1:0] req_chunk_data,
    output logic [NumReq-1:0]    req_chunk_pop,
    output logic                 mac_chunk_valid,
    output logic [AW-1:0]        mac_chunk_addr,
    output logic [DW-1:0]        mac_chunk_data,
    input  logic                 mac_result_valid,
    input  logic [DW-1:0]        mac_result_data,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [TW-1:0]        out_tag,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 err_sticky
);

    localparam int unsigned PW = $clog2(OutFifoDepth);
    localparam int unsigned CW = $clog2(OutFifoDepth + 1);
    localparam logic [AW-1:0] LastChunk = AW'(Chunks - 1);

    typedef enum logic {IDLE, ISSUE} state_e;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          last;
    } fifo_entry_t;

    typedef struct packed {
        logic          valid;
        logic [TW-1:0] tag;
        logic          last;
    } tag_entry_t;

    state_e        state_q, state_d;
    logic [TW-1:0] grant_q, grant_d;
    logic [TW-1:0] rr_ptr_q, rr_ptr_d, next_ptr;
    logic [AW-1:0] chunk_cnt_q, chunk_cnt_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          err_q, err_d;
    fifo_entry_t   mem_q [OutFifoDepth];
    tag_entry_t    pipe_q [MacLatency];
    tag_entry_t    tag_push, tail;
    fifo_entry_t   head;
    logic [DW-1:0] req_chunks [NumReq];
    logic [CW:0]   occupancy;
    logic          credit_ok, issue, is_last, result_ok, fifo_full, fifo_wr, fifo_rd, drop;

    // First requester with valid set, scanning upward from ptr with wrap.
    function automatic logic [TW-1:0] rr_pick(input logic [TW-1:0] ptr,
                                              input logic [NumReq-1:0] vld);
        logic [TW-1:0] pick;
        int unsigned   idx;
        pick = ptr;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            idx = (32'(ptr) + 32'(i)) % NumReq;
            if (vld[TW'(idx)]) pick = TW'(idx);
        end
        return pick;
    endfunction

    // Unpack the per-requester head chunks and mux the granted one to the engine.
    always_comb begin
        for (int r = 0; r < int'(NumReq); r++) req_chunks[r] = req_chunk_data[r*DW +: DW];
    end
    assign mac_chunk_data = req_chunks[grant_q];

    assign occupancy = (CW+1)'(count_q) + (CW+1)'(inflight_q);
    assign credit_ok = occupancy < (CW+1)'(OutFifoDepth);
    assign is_last   = (chunk_cnt_q == LastChunk);
    assign next_ptr  = (grant_q == TW'(NumReq - 1)) ? '0 : grant_q + TW'(1);

    // Arbitration / issue FSM: whole-vector grants, back-to-back re-arbitration on the last chunk.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        chunk_cnt_d = chunk_cnt_q;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d     = rr_pick(rr_ptr_q, req_valid);
                    chunk_cnt_d = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (is_last) begin
                        rr_ptr_d    = next_ptr;
                        chunk_cnt_d = '0;
                        if (|req_valid) grant_d = rr_pick(next_ptr, req_valid);
                        else            state_d = IDLE;
                    end else begin
                        chunk_cnt_d = chunk_cnt_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_chunk_pop   = issue ? (NumReq'(1) << grant_q) : '0;
    assign mac_chunk_valid = issue;
    assign mac_chunk_addr  = issue ? chunk_cnt_q : '0;

    // Tag pipe entry pushed alongside each issued chunk.
    always_comb begin
        tag_push = '0;
        if (issue) begin
            tag_push.valid = 1'b1;
            tag_push.tag   = grant_q;
            tag_push.last  = is_last;
        end
    end
    assign tail = pipe_q[MacLatency-1];

    assign result_ok = mac_result_valid && tail.valid;
    assign fifo_full = (count_q == CW'(OutFifoDepth));
    assign fifo_rd   = (count_q != '0) && out_ready;
    assign drop      = result_ok && fifo_full && !fifo_rd;
    assign fifo_wr   = result_ok && !drop;

    // Credit, FIFO pointer and error next-state.
    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q;
        if (issue && !result_ok)      inflight_d = inflight_q + CW'(1);
        else if (!issue && result_ok) inflight_d = inflight_q - CW'(1);
        if (fifo_wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (fifo_rd) rd_ptr_d = rd_ptr_q + PW'(1);
        if (fifo_wr && !fifo_rd)      count_d = count_q + CW'(1);
        else if (!fifo_wr && fifo_rd) count_d = count_q - CW'(1);
        if ((mac_result_valid != tail.valid) || drop) err_d = 1'b1;
    end

    // Control state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            chunk_cnt_q <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < int'(MacLatency); i++) pipe_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            chunk_cnt_q <= chunk_cnt_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            pipe_q[0]   <= tag_push;
            for (int i = 1; i < int'(MacLatency); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_in) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= '{data: mac_result_data, tag: tail.tag, last: tail.last};
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? head.data : '0;
    assign out_tag    = out_valid ? head.tag  : '0;
    assign out_last   = out_valid ? head.last : 1'b0;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_vwb_rr_scheduler.sv
// tb_vwb_rr_scheduler: directed bench with requester/engine stubs and an output scoreboard.
module tb_vwb_rr_scheduler;

    localparam int unsigned NumReq = 4;
    localparam int unsigned DW     = 64;

    logic                 clk = 1'b0;
    logic                 rst_in = 1'b1;
    logic [NumReq-1:0]    req_valid = '0;
    logic [NumReq*DW-1:0] req_chunk_data;
    logic [NumReq-1:0]    req_chunk_pop;
    logic                 mac_chunk_valid;
    logic [1:0]           mac_chunk_addr;
    logic [DW-1:0]        mac_chunk_data;
    logic                 mac_result_valid;
    logic [DW-1:0]        mac_result_data;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [1:0]           out_tag;
    logic                 out_last;
    logic                 out_ready = 1'b1;
    logic                 err_sticky;

    logic                 eng_v = 1'b0;
    logic [DW-1:0]        eng_d = '0;
    logic                 force_res = 1'b0;
    int unsigned          head [NumReq] = '{default: 0};
    int unsigned          exp_seq [NumReq] = '{default: 0};
    logic [DW+2:0]        sb_q [$];
    int                   tests = 0;
    int                   fails = 0;

    always #5 clk = ~clk;

    vwb_rr_scheduler #(
        .NumReq(4), .InVecLength(16), .WorkingRegs(4), .NBits(16),
        .MacLatency(1), .OutFifoDepth(4)
    ) dut (
        .clk_in(clk), .rst_in(rst_in),
        .req_valid(req_valid), .req_chunk_data(req_chunk_data), .req_chunk_pop(req_chunk_pop),
        .mac_chunk_valid(mac_chunk_valid), .mac_chunk_addr(mac_chunk_addr),
        .mac_chunk_data(mac_chunk_data), .mac_result_valid(mac_result_valid),
        .mac_result_data(mac_result_data), .out_valid(out_valid), .out_data(out_data),
        .out_tag(out_tag), .out_last(out_last), .out_ready(out_ready), .err_sticky(err_sticky)
    );

    function automatic logic [DW-1:0] mkdata(input int r, input int unsigned seq);
        return {16'(r + 1), 16'(seq), 16'(seq * 37 + 32'(r)), 16'hC0DE ^ 16'(seq)};
    endfunction

    function automatic logic [DW-1:0] pat(input int k);
        return {4{4'(k + 1), 12'h5A3}};
    endfunction

    // Requester FIFO stub: head chunk index advances on pop; a reset drops the partial vector.
    always_comb begin
        for (int r = 0; r < int'(NumReq); r++) req_chunk_data[r*DW +: DW] = mkdata(r, head[r]);
    end
    always @(posedge clk) begin
        for (int r = 0; r < int'(NumReq); r++)
            head[r] <= rst_in ? ((head[r] + 32'(req_chunk_pop[r]) + 3) / 4) * 4
                              : head[r] + 32'(req_chunk_pop[r]);
    end

    // Engine stub: one-cycle latency, result = chunk XOR an address-dependent pattern.
    always @(posedge clk) begin
        eng_v <= rst_in ? 1'b0 : mac_chunk_valid;
        eng_d <= mac_chunk_data ^ pat(int'(mac_chunk_addr));
    end
    assign mac_result_valid = eng_v | force_res;
    assign mac_result_data  = eng_d;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_issue(input string tag, input logic v, input logic [3:0] pop,
                               input logic [1:0] addr);
        check(tag, 128'({mac_chunk_valid, req_chunk_pop, mac_chunk_addr}), 128'({v, pop, addr}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_vector(input int r);
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back({mkdata(r, exp_seq[r]) ^ pat(k), 2'(r), (k == 3)});
            exp_seq[r]++;
        end
    endtask

    // One isolated vector: arbitration cycle, four issue cycles, then idle.
    task automatic do_vector(input logic [3:0] rv, input int r, input string tag);
        expect_vector(r);
        req_valid = rv;
        #1;
        check_issue({tag, "_arb"}, 1'b0, 4'b0, 2'd0);
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_issue({tag, "_chunk"}, 1'b1, 4'(1 << r), 2'(k));
            tick();
        end
        #1;
        check_issue({tag, "_idle"}, 1'b0, 4'b0, 2'd0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
        check(tag, 128'(sb_q.size()), 128'(0));
        tick();
        check({tag, "_empty"}, 128'(out_valid), 128'(0));
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        sb_q.delete();
    endtask

    // Output scoreboard: every consumed head must match the next expected entry.
    always @(negedge clk) begin
        if (!rst_in && out_valid && out_ready) begin
            if (sb_q.size() == 0) check("sb_extra", 128'(out_valid), 128'(0));
            else check("sb_out", 128'({out_data, out_tag, out_last}), 128'(sb_q.pop_front()));
        end
    end

    initial begin
        int n;
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        tick();
        tick();
        rst_in = 1'b0;
        #1;
        check("reset_outs", 128'({req_chunk_pop, mac_chunk_valid, mac_chunk_addr, out_valid,
                                  out_data, out_tag, out_last, err_sticky}), 128'(0));

        // Single requester vector.
        do_vector(4'b0001, 0, "single");
        drain("single_drain");

        // All requesters valid: 0,1,2,3,0 with no bubble.
        do_reset();
        for (int r = 0; r < 4; r++) expect_vector(r);
        expect_vector(0);
        req_valid = 4'b1111;
        #1;
        check_issue("all_arb", 1'b0, 4'b0, 2'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            #1;
            check_issue("all_chunk", 1'b1, order[i/4], 2'(i % 4));
            if (i == 16) req_valid = '0;
            tick();
        end
        #1;
        check_issue("all_idle", 1'b0, 4'b0, 2'd0);
        drain("all_drain");

        // Backpressure: rr_ptr is 1 here, so grant 1 then 2; credit allows exactly 4.
        out_ready = 1'b0;
        expect_vector(1);
        expect_vector(2);
        req_valid = 4'b0110;
        tick();
        req_valid = 4'b0100;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mac_chunk_valid) n++;
            if (i == 5) req_valid = '0;
            tick();
        end
        check("bp_stall_issues", 128'(n), 128'(4));
        check("bp_out_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mac_chunk_valid) n++;
            tick();
        end
        check("bp_resume_issues", 128'(n), 128'(4));
        drain("bp_drain");

        // Pointer wrap: rr_ptr=1 after a requester-0 vector.
        do_reset();
        do_vector(4'b0001, 0, "wrap_r0");
        do_vector(4'b0100, 2, "wrap_r2");
        do_vector(4'b0011, 0, "wrap_r0b");
        drain("wrap_drain");

        // Reset mid-vector: partial vector discarded, arbitration restarts at requester 0.
        out_ready = 1'b0;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_issue("mid_chunk", 1'b1, 4'b0010, 2'(k));
            if (k < 2) tick();
        end
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        exp_seq[1] += 4;
        #1;
        check("mid_rst_outs", 128'({req_chunk_pop, mac_chunk_valid, mac_chunk_addr, out_valid,
                                    out_data, out_tag, out_last, err_sticky}), 128'(0));
        out_ready = 1'b1;
        do_vector(4'b0011, 0, "post_rst");
        drain("post_rst_drain");

        // Spurious result: sticky error, FIFO contents unchanged.
        out_ready = 1'b0;
        do_vector(4'b0001, 0, "err_fill");
        tick();
        tick();
        check("err_before", 128'(err_sticky), 128'(0));
        force_res = 1'b1;
        tick();
        force_res = 1'b0;
        #1;
        check("err_set", 128'(err_sticky), 128'(1));
        for (int i = 0; i < 3; i++) tick();
        check("err_hold", 128'(err_sticky), 128'(1));
        out_ready = 1'b1;
        drain("err_drain");
        check("err_hold2", 128'(err_sticky), 128'(1));
        do_reset();
        #1;
        check("err_cleared", 128'(err_sticky), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
